hc04_ranger: RTL and testbench

//  Synthesisable multi-channel HC-SR04 ultrasonic ranging controller; successor to the

---
 rtl/hc04_ranger.sv | 185 ++++++++++++++++++
 tb/tb_hc04_ranger.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hc04_ranger.sv
// Round-robin HC-SR04 ranging controller: triggers one sensor at a time, times
// its echo in prescaled ticks and reports one result (or a timeout) per ping.
module hc04_ranger #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 16,
  parameter int PRESCALE      = 50,
  parameter int TRIG_CYCLES   = 500,
  parameter int TIMEOUT_TICKS = 30000,
  parameter int GAP_CYCLES    = 3000000,
  localparam int CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CHANNELS-1:0] channel_mask,
  output logic [CHANNELS-1:0] hc04_trigger,
  input  logic [CHANNELS-1:0] hc04_echo,
  output logic                busy,
  output logic                result_valid,
  output logic [CW-1:0]       result_channel,
  output logic [WIDTH-1:0]    result_distance,
  output logic                result_timeout
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE + 1) : 1;
  localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'((PRESCALE > 0) ? PRESCALE - 1 : 0);
  localparam logic [TW-1:0] TRIG_LAST  = TW'((TRIG_CYCLES > 0) ? TRIG_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  // A limit that does not fit the counter is reached by saturation instead.
  localparam logic [WIDTH-1:0] TO_LIMIT =
    ($clog2(TIMEOUT_TICKS + 1) > WIDTH) ? CNT_MAX : WIDTH'(TIMEOUT_TICKS);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;

  state_t               state_reg;
  logic [CW-1:0]        ptr_reg;
  logic [CW-1:0]        sel_reg;
  logic [TW-1:0]        trig_cnt_reg;
  logic [PW-1:0]        presc_reg;
  logic [WIDTH-1:0]     count_reg;
  logic [GW-1:0]        gap_cnt_reg;
  logic [CHANNELS-1:0]  echo_meta;
  logic [CHANNELS-1:0]  echo_sync;
  logic [CHANNELS-1:0]  echo_prev;

  logic [CW-1:0]        pick;
  logic [CHANNELS-1:0]  pick_onehot;
  logic [CW-1:0]        ptr_next;
  logic [WIDTH-1:0]     count_inc;
  logic                 tick;
  logic                 echo_rise;
  logic                 echo_fall;

  // First masked channel at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    logic found;
    pick  = ptr_reg;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(ptr_reg) + i) % CHANNELS;
      if (!found && channel_mask[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pick_onehot[i] = (pick == CW'(i));
    end
  end

  assign ptr_next  = (sel_reg == CW'(CHANNELS - 1)) ? '0 : sel_reg + 1'b1;
  assign tick      = (presc_reg == PRESC_LAST);
  assign count_inc = (count_reg == CNT_MAX) ? count_reg : count_reg + 1'b1;
  assign echo_rise = echo_sync[sel_reg] & ~echo_prev[sel_reg];
  assign echo_fall = ~echo_sync[sel_reg] & echo_prev[sel_reg];
  assign busy      = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      sel_reg         <= '0;
      trig_cnt_reg    <= '0;
      presc_reg       <= '0;
      count_reg       <= '0;
      gap_cnt_reg     <= '0;
      echo_meta       <= '0;
      echo_sync       <= '0;
      echo_prev       <= '0;
      hc04_trigger    <= '0;
      result_valid    <= 1'b0;
      result_channel  <= '0;
      result_distance <= '0;
      result_timeout  <= 1'b0;
    end else begin
      echo_meta    <= hc04_echo;
      echo_sync    <= echo_meta;
      echo_prev    <= echo_sync;
      result_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable && |channel_mask) begin
            sel_reg      <= pick;
            hc04_trigger <= pick_onehot;
            trig_cnt_reg <= '0;
            state_reg    <= TRIG;
          end
        end
        TRIG: begin
          if (trig_cnt_reg == TRIG_LAST) begin
            hc04_trigger <= '0;
            presc_reg    <= '0;
            count_reg    <= '0;
            state_reg    <= WAIT_RISE;
          end else begin
            trig_cnt_reg <= trig_cnt_reg + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            presc_reg <= '0;
            count_reg <= '0;
            state_reg <= MEASURE;
          end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
              count_reg <= count_inc;
              if (count_inc >= TO_LIMIT) begin
                result_valid    <= 1'b1;
                result_channel  <= sel_reg;
                result_distance <= '1;
                result_timeout  <= 1'b1;
                gap_cnt_reg     <= '0;
                state_reg       <= GAP;
              end
            end
          end
        end
        MEASURE: begin
          // A falling edge wins over a tick landing in the same cycle.
          if (echo_fall) begin
            result_valid    <= 1'b1;
            result_channel  <= sel_reg;
            result_distance <= count_reg;
            result_timeout  <= 1'b0;
            gap_cnt_reg     <= '0;
            state_reg       <= GAP;
          end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
              count_reg <= count_inc;
              if (count_inc >= TO_LIMIT) begin
                result_valid    <= 1'b1;
                result_channel  <= sel_reg;
                result_distance <= '1;
                result_timeout  <= 1'b1;
                gap_cnt_reg     <= '0;
                state_reg       <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            ptr_reg   <= ptr_next;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc04_ranger.sv
// Directed bench for hc04_ranger: a table of pings with hand-computed results,
// then hand-written sequences for idle masking, async reset and enable drop.
module tb_hc04_ranger;

  localparam int CHANNELS = 2;
  localparam int WIDTH    = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic [CHANNELS-1:0] channel_mask;
  logic [CHANNELS-1:0] hc04_trigger;
  logic [CHANNELS-1:0] hc04_echo;
  logic                busy;
  logic                result_valid;
  logic [0:0]          result_channel;
  logic [WIDTH-1:0]    result_distance;
  logic                result_timeout;

  hc04_ranger #(
    .CHANNELS(CHANNELS), .WIDTH(WIDTH), .PRESCALE(4), .TRIG_CYCLES(10),
    .TIMEOUT_TICKS(200), .GAP_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .channel_mask(channel_mask),
    .hc04_trigger(hc04_trigger), .hc04_echo(hc04_echo), .busy(busy),
    .result_valid(result_valid), .result_channel(result_channel),
    .result_distance(result_distance), .result_timeout(result_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [1:0] mask;
    int         delay;   // clks after trigger fall until echo rises, -1 = never
    int         high;    // echo high time in clks
    int         exp_ch;
    int         dmin;
    int         dmax;
    int         exp_to;
    int         exp_lat; // clks from WAIT_RISE entry to result, -1 = unchecked
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic wait_trig(output int ch, output int waited);
    waited = 0;
    while (hc04_trigger == 2'b00 && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    ch = (hc04_trigger == 2'b01) ? 0 : (hc04_trigger == 2'b10) ? 1 : -1;
  endtask

  task automatic trig_width(output int width);
    width = 0;
    while (hc04_trigger != 2'b00 && width < 100) begin
      @(negedge clk);
      width++;
    end
  endtask

  task automatic run_ping(input vec_t v, input int idx, input bit check_gap);
    int ch, waited, width, k, overlap;
    bit got, on;
    channel_mask = v.mask;
    wait_trig(ch, waited);
    check($sformatf("v%0d trig_ch", idx), ch, v.exp_ch, v.exp_ch);
    if (ch < 0) return;
    if (check_gap) check($sformatf("v%0d gap", idx), waited + 1, 21, 21);
    trig_width(width);
    check($sformatf("v%0d trig_width", idx), width, 10, 10);
    got = 1'b0;
    k = 0;
    overlap = 0;
    while (!got && k < 3000) begin
      if (result_valid) begin
        got = 1'b1;
      end else begin
        if (hc04_trigger != 2'b00) overlap++;
        on = (v.delay >= 0) && (k >= v.delay) && (k < v.delay + v.high);
        hc04_echo = on ? ((ch == 1) ? 2'b10 : 2'b01) : 2'b00;
        @(negedge clk);
        k++;
      end
    end
    hc04_echo = 2'b00;
    check($sformatf("v%0d result_seen", idx), got, 1, 1);
    check($sformatf("v%0d result_ch", idx), result_channel, v.exp_ch, v.exp_ch);
    check($sformatf("v%0d distance", idx), result_distance, v.dmin, v.dmax);
    check($sformatf("v%0d timeout", idx), result_timeout, v.exp_to, v.exp_to);
    check($sformatf("v%0d trig_overlap", idx), overlap, 0, 0);
    if (v.exp_lat >= 0) check($sformatf("v%0d latency", idx), k, v.exp_lat, v.exp_lat);
    $display("ping %0d: ch=%0d dist=%0d timeout=%0d after %0d clk", idx,
             result_channel, result_distance, result_timeout, k);
    @(negedge clk);
    check($sformatf("v%0d strobe_once", idx), result_valid, 0, 0);
    check($sformatf("v%0d dist_hold", idx), result_distance, v.dmin, v.dmax);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch, waited, width, results, trig_hi, to_seen;

    vecs[0] = '{mask: 2'b11, delay: 20, high: 400,  exp_ch: 0, dmin: 99,   dmax: 101,  exp_to: 0, exp_lat: -1};
    vecs[1] = '{mask: 2'b11, delay: -1, high: 0,    exp_ch: 1, dmin: 4095, dmax: 4095, exp_to: 1, exp_lat: 800};
    vecs[2] = '{mask: 2'b11, delay: 20, high: 2000, exp_ch: 0, dmin: 4095, dmax: 4095, exp_to: 1, exp_lat: 823};
    vecs[3] = '{mask: 2'b11, delay: 5,  high: 1,    exp_ch: 1, dmin: 0,    dmax: 0,    exp_to: 0, exp_lat: -1};
    vecs[4] = '{mask: 2'b10, delay: 10, high: 40,   exp_ch: 1, dmin: 9,    dmax: 11,   exp_to: 0, exp_lat: -1};
    vecs[5] = '{mask: 2'b10, delay: 10, high: 80,   exp_ch: 1, dmin: 19,   dmax: 21,   exp_to: 0, exp_lat: -1};
    vecs[6] = '{mask: 2'b01, delay: 3,  high: 100,  exp_ch: 0, dmin: 24,   dmax: 26,   exp_to: 0, exp_lat: -1};

    rst = 1'b1;
    enable = 1'b1;
    channel_mask = 2'b11;
    hc04_echo = 2'b00;
    #1;
    check("reset trigger", hc04_trigger, 0, 0);
    check("reset busy", busy, 0, 0);
    check("reset valid", result_valid, 0, 0);
    check("reset distance", result_distance, 0, 0);
    check("reset timeout", result_timeout, 0, 0);
    check("reset channel", result_channel, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_ping(vecs[i], i, i != 0);

    // Empty mask: the current GAP finishes, then nothing more happens.
    channel_mask = 2'b00;
    trig_hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hc04_trigger != 2'b00) trig_hi++;
    end
    check("mask00 trigger", trig_hi, 0, 0);
    check("mask00 busy", busy, 0, 0);
    $display("mask00: busy=%0d trigger_samples=%0d", busy, trig_hi);

    // Async reset in the middle of a measurement on ch1.
    channel_mask = 2'b11;
    wait_trig(ch, waited);
    check("pre_rst trig_ch", ch, 1, 1);
    trig_width(width);
    for (int k = 0; k < 100; k++) begin
      hc04_echo = (k >= 5) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    #3 rst = 1'b1;
    #1;
    check("rst trigger", hc04_trigger, 0, 0);
    check("rst valid", result_valid, 0, 0);
    check("rst busy", busy, 0, 0);
    hc04_echo = 2'b00;
    #4 rst = 1'b0;
    @(negedge clk);
    wait_trig(ch, waited);
    check("post_rst trig_ch", ch, 0, 0);
    $display("reset: first ping after release on ch=%0d", ch);

    // Enable dropped during TRIG: this ping still finishes, then nothing.
    enable = 1'b0;
    trig_width(width);
    check("endrop trig_width", width, 10, 10);
    results = 0;
    trig_hi = 0;
    to_seen = 0;
    for (int i = 0; i < 1100; i++) begin
      if (result_valid) begin
        results++;
        to_seen = result_timeout;
      end
      if (hc04_trigger != 2'b00) trig_hi++;
      @(negedge clk);
    end
    check("endrop results", results, 1, 1);
    check("endrop timeout", to_seen, 1, 1);
    check("endrop channel", result_channel, 0, 0);
    check("endrop trigger", trig_hi, 0, 0);
    check("endrop busy", busy, 0, 0);
    $display("enable drop: results=%0d timeout=%0d busy=%0d", results, to_seen, busy);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
